// File: rtl/mul_div_unit_pkg.sv
// Shared types for the HI/LO multiply-divide unit:
// operation codes, default latencies and the divide helper.
package mul_div_unit_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSV   = 3'd7
   } md_op_e;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } md_res_t;

   // Divides magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
   function automatic md_res_t md_divide(
      input logic [31:0] a,
      input logic [31:0] b,
      input logic        sgn
   );
      md_res_t     r;
      logic        na;
      logic        nb;
      logic [31:0] ma;
      logic [31:0] mb;
      logic [31:0] q;
      logic [31:0] m;
      na = sgn & a[31];
      nb = sgn & b[31];
      ma = na ? -a : a;
      mb = nb ? -b : b;
      if (mb == 32'd0) mb = 32'd1;
      q = ma / mb;
      m = ma % mb;
      r.lo = (na ^ nb) ? -q : q;
      r.hi = na ? -m : m;
      return r;
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Operands are latched at issue; HI/LO commit as the counter reaches zero.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

   md_op_e        op_in;
   logic          is_long;

   logic [CW-1:0] cnt_q, cnt_d;
   md_op_e        op_q, op_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;

   logic signed [63:0] a_sx;
   logic signed [63:0] b_sx;
   logic [63:0]        prod_s;
   logic [63:0]        prod_u;
   md_res_t            div_r;
   md_res_t            res;
   logic               div0;

   assign op_in   = md_op_e'(md_op);
   assign is_long = start & ((op_in == MD_MULT) | (op_in == MD_MULTU) |
                             (op_in == MD_DIV)  | (op_in == MD_DIVU));

   assign busy      = (cnt_q != '0);
   assign stall_req = busy | is_long;
   assign hi        = hi_q;
   assign lo        = lo_q;

   assign a_sx   = {{32{a_q[31]}}, a_q};
   assign b_sx   = {{32{b_q[31]}}, b_q};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};
   assign div_r  = md_divide(a_q, b_q, op_q == MD_DIV);
   assign div0   = ((op_q == MD_DIV) | (op_q == MD_DIVU)) & (b_q == 32'd0);

   always_comb begin
      res = {hi_q, lo_q};
      unique case (op_q)
         MD_MULT:         res = prod_s;
         MD_MULTU:        res = prod_u;
         MD_DIV, MD_DIVU: res = div_r;
         default:         res = {hi_q, lo_q};
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      op_d  = op_q;
      a_d   = a_q;
      b_d   = b_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      if (busy) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1) && !div0) begin
            hi_d = res.hi;
            lo_d = res.lo;
         end
      end else if (start) begin
         unique case (op_in)
            MD_MULT, MD_MULTU: begin
               op_d  = op_in;
               a_d   = A;
               b_d   = B;
               cnt_d = CW'(MULT_CYCLES);
            end
            MD_DIV, MD_DIVU: begin
               op_d  = op_in;
               a_d   = A;
               b_d   = B;
               cnt_d = CW'(DIV_CYCLES);
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         op_q  <= MD_NONE;
         a_q   <= '0;
         b_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         op_q  <= op_d;
         a_q   <= a_d;
         b_q   <= b_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, hazards, reset.
module tb_mul_div_unit;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam logic [2:0] OP_RSV   = 3'd7;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   int tests = 0;
   int fails = 0;

   mul_div_unit #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .md_op    (md_op),
      .A        (A),
      .B        (B),
      .busy     (busy),
      .stall_req(stall_req),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      md_op = op;
      A     = a;
      B     = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      md_op = OP_NONE;
   endtask

   // Counts busy cycles from c0 and checks stall_req tracks busy.
   task automatic run(input string tag, input int n, input int c0);
      int c;
      bit stall_ok;
      c        = c0;
      stall_ok = 1'b1;
      while (busy && c < 50) begin
         if (!stall_req) stall_ok = 1'b0;
         @(posedge clk);
         #1;
         c++;
      end
      chk({tag, "_cycles"}, 64'(c), 64'(n));
      chk({tag, "_stall"}, 64'(stall_ok), 64'd1);
   endtask

   initial begin
      clk   = 1'b0;
      reset = 1'b1;
      start = 1'b0;
      md_op = OP_NONE;
      A     = '0;
      B     = '0;
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_stall", 64'(stall_req), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
      chk("mult_busy", 64'(busy), 64'd1);
      chk("mult_old", {hi, lo}, 64'd0);
      run("mult", 5, 0);
      chk("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);

      issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
      chk("multu_old", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
      run("multu", 5, 0);
      chk("multu_res", {hi, lo}, 64'h00000001_FFFFFFFE);

      issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
      run("div", 10, 0);
      chk("div_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

      issue(OP_DIVU, 32'd7, 32'd2);
      run("divu", 10, 0);
      chk("divu_res", {hi, lo}, 64'h00000001_00000003);

      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      run("div_ovf", 10, 0);
      chk("div_ovf_res", {hi, lo}, 64'h00000000_80000000);

      @(negedge clk);
      start = 1'b1;
      md_op = OP_MTHI;
      A     = 32'h12345678;
      #1;
      chk("mthi_stall", 64'(stall_req), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      md_op = OP_NONE;
      chk("mthi_busy", 64'(busy), 64'd0);
      chk("mthi_res", {hi, lo}, 64'h12345678_80000000);

      issue(OP_DIV, 32'd100, 32'd7);
      @(posedge clk);
      #1;
      @(negedge clk);
      start = 1'b1;
      md_op = OP_MULT;
      A     = 32'd3;
      B     = 32'd4;
      #1;
      chk("ign_stall", 64'(stall_req), 64'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      md_op = OP_NONE;
      run("ign", 10, 2);
      chk("ign_res", {hi, lo}, 64'h00000002_0000000E);

      issue(OP_MTHI, 32'hAA, 32'd0);
      issue(OP_MTLO, 32'hBB, 32'd0);
      chk("mtlo_res", {hi, lo}, 64'h000000AA_000000BB);
      issue(OP_DIVU, 32'd5, 32'd0);
      chk("dz_busy", 64'(busy), 64'd1);
      run("dz", 10, 0);
      chk("dz_res", {hi, lo}, 64'h000000AA_000000BB);

      @(negedge clk);
      start = 1'b1;
      md_op = OP_RSV;
      A     = 32'hDEADBEEF;
      B     = 32'd1;
      #1;
      chk("rsv_stall", 64'(stall_req), 64'd0);
      @(negedge clk);
      md_op = OP_NONE;
      #1;
      chk("none_stall", 64'(stall_req), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("noop_busy", 64'(busy), 64'd0);
      chk("noop_res", {hi, lo}, 64'h000000AA_000000BB);

      issue(OP_MULT, 32'd3, 32'd4);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("mrst_busy2", 64'(busy), 64'd0);
      chk("mrst_hilo2", {hi, lo}, 64'd0);

      issue(OP_MULT, 32'd2, 32'd3);
      run("b2b1", 5, 0);
      chk("b2b1_res", {hi, lo}, 64'd6);
      chk("b2b_idle_busy", 64'(busy), 64'd0);
      issue(OP_MULT, 32'd4, 32'd5);
      chk("b2b2_busy", 64'(busy), 64'd1);
      run("b2b2", 5, 0);
      chk("b2b2_res", {hi, lo}, 64'd20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
